// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-FU one-entry holding buffers, round-robin grant of up to
// CDB_WIDTH buffers per cycle, registered broadcast slots.
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int CDB_WIDTH = 2,
    parameter int TAG_W     = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  logic [NUM_FU-1:0]            fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]      fu_tag,
    input  logic [NUM_FU*`XLEN-1:0]      fu_result,
    input  logic [NUM_FU-1:0]            fu_take_branch,
    output logic [NUM_FU-1:0]            fu_ready,
    output logic [CDB_WIDTH-1:0]         cdb_valid,
    output logic [CDB_WIDTH*TAG_W-1:0]   cdb_tag,
    output logic [CDB_WIDTH*`XLEN-1:0]   cdb_value,
    output logic [CDB_WIDTH-1:0]         cdb_take_branch
);

    localparam int XW    = `XLEN;
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]    buf_valid_p0;
    logic [TAG_W-1:0]     buf_tag_p0    [NUM_FU];
    logic [XW-1:0]        buf_value_p0  [NUM_FU];
    logic [NUM_FU-1:0]    buf_br_p0;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_next;
    logic [NUM_FU-1:0]    grant;
    logic [NUM_FU-1:0]    slot_hit      [CDB_WIDTH];
    logic [CDB_WIDTH-1:0] slot_vld;
    logic [TAG_W-1:0]     slot_tag      [CDB_WIDTH];
    logic [XW-1:0]        slot_value    [CDB_WIDTH];
    logic [CDB_WIDTH-1:0] slot_br;

    // Each buffer's rank = number of valid buffers ahead of it in round-robin order from rr_ptr.
    always_comb begin
        int pos [NUM_FU];
        int rank;
        int best;
        grant   = '0;
        rr_next = rr_ptr;
        best    = -1;
        for (int s = 0; s < CDB_WIDTH; s++) slot_hit[s] = '0;
        for (int i = 0; i < NUM_FU; i++)
            pos[i] = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + NUM_FU - int'(rr_ptr));
        for (int i = 0; i < NUM_FU; i++) begin
            rank = 0;
            for (int j = 0; j < NUM_FU; j++)
                if (buf_valid_p0[j] && pos[j] < pos[i]) rank++;
            if (!squash && buf_valid_p0[i] && rank < CDB_WIDTH) begin
                grant[i] = 1'b1;
                for (int s = 0; s < CDB_WIDTH; s++)
                    if (s == rank) slot_hit[s][i] = 1'b1;
                if (pos[i] > best) begin
                    best    = pos[i];
                    rr_next = (i == NUM_FU - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < CDB_WIDTH; s++) begin
            slot_vld[s]   = 1'b0;
            slot_tag[s]   = '0;
            slot_value[s] = '0;
            slot_br[s]    = 1'b0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (slot_hit[s][i]) begin
                    slot_vld[s]   = 1'b1;
                    slot_tag[s]   = slot_tag[s]   | buf_tag_p0[i];
                    slot_value[s] = slot_value[s] | buf_value_p0[i];
                    slot_br[s]    = slot_br[s]    | buf_br_p0[i];
                end
            end
        end
    end

    assign fu_ready = (~buf_valid_p0 | grant) & {NUM_FU{~squash}};

    // ---- stage p0: holding buffers ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_valid_p0 <= '0;
            rr_ptr       <= '0;
        end else if (squash) begin
            buf_valid_p0 <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) buf_valid_p0[i] <= 1'b1;
                else if (grant[i])              buf_valid_p0[i] <= 1'b0;
            end
            if (|grant) rr_ptr <= rr_next;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) begin
                buf_tag_p0[i]   <= fu_tag[i*TAG_W +: TAG_W];
                buf_value_p0[i] <= fu_result[i*XW +: XW];
                buf_br_p0[i]    <= fu_take_branch[i];
            end
        end
    end

    // ---- stage p1: registered broadcast slots ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid       <= '0;
            cdb_tag         <= '0;
            cdb_value       <= '0;
            cdb_take_branch <= '0;
        end else begin
            for (int s = 0; s < CDB_WIDTH; s++) begin
                cdb_valid[s]                <= slot_vld[s];
                cdb_tag[s*TAG_W +: TAG_W]   <= slot_tag[s];
                cdb_value[s*XW +: XW]       <= slot_value[s];
                cdb_take_branch[s]          <= slot_br[s];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based round-robin model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_cdb_arbiter;

    localparam int NF = 4;
    localparam int CW = 2;
    localparam int TW = 5;
    localparam int XW = `XLEN;

    logic             clock;
    logic             reset;
    logic             squash;
    logic [NF-1:0]    fu_valid;
    logic [NF*TW-1:0] fu_tag;
    logic [NF*XW-1:0] fu_result;
    logic [NF-1:0]    fu_take_branch;
    logic [NF-1:0]    fu_ready;
    logic [CW-1:0]    cdb_valid;
    logic [CW*TW-1:0] cdb_tag;
    logic [CW*XW-1:0] cdb_value;
    logic [CW-1:0]    cdb_take_branch;

    cdb_arbiter #(.NUM_FU(NF), .CDB_WIDTH(CW), .TAG_W(TW)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_result(fu_result),
        .fu_take_branch(fu_take_branch), .fu_ready(fu_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_take_branch(cdb_take_branch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          v;
        logic [TW-1:0] tag;
        logic [XW-1:0] val;
        bit          br;
    } ent_t;

    ent_t m_buf [NF];
    int   m_ptr;
    int   checks;
    int   failures;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NF; i++) m_buf[i].v = 0;
        m_ptr = 0;
    endtask

    task automatic drive(input int i, input int tag, input int val, input bit br);
        fu_valid[i]            = 1'b1;
        fu_tag[i*TW +: TW]     = TW'(tag);
        fu_result[i*XW +: XW]  = XW'(val);
        fu_take_branch[i]      = br;
    endtask

    task automatic idle_inputs();
        fu_valid = '0; squash = 1'b0;
    endtask

    // Called at the falling edge with inputs already driven; advances one clock.
    task automatic cycle();
        int gq[$];
        bit granted [NF];
        logic [NF-1:0]    exp_rdy;
        logic [CW-1:0]    exp_v;
        logic [CW*TW-1:0] exp_tag;
        logic [CW*XW-1:0] exp_val;
        logic [CW-1:0]    exp_br;
        #1;
        for (int k = 0; k < NF; k++) begin
            int i;
            i = (m_ptr + k) % NF;
            granted[i] = 0;
        end
        for (int k = 0; k < NF; k++) begin
            int i;
            i = (m_ptr + k) % NF;
            if (!squash && m_buf[i].v && gq.size() < CW) begin
                gq.push_back(i);
                granted[i] = 1;
            end
        end
        for (int i = 0; i < NF; i++) exp_rdy[i] = (!m_buf[i].v || granted[i]) && !squash;
        check("fu_ready", 64'(fu_ready), 64'(exp_rdy));
        exp_v = '0; exp_tag = '0; exp_val = '0; exp_br = '0;
        for (int s = 0; s < gq.size(); s++) begin
            exp_v[s]              = 1'b1;
            exp_tag[s*TW +: TW]   = m_buf[gq[s]].tag;
            exp_val[s*XW +: XW]   = m_buf[gq[s]].val;
            exp_br[s]             = m_buf[gq[s]].br;
        end
        for (int i = 0; i < NF; i++) begin
            if (squash) m_buf[i].v = 0;
            else if (fu_valid[i] && exp_rdy[i]) begin
                m_buf[i].v   = 1;
                m_buf[i].tag = fu_tag[i*TW +: TW];
                m_buf[i].val = fu_result[i*XW +: XW];
                m_buf[i].br  = fu_take_branch[i];
            end else if (granted[i]) m_buf[i].v = 0;
        end
        if (gq.size() > 0) m_ptr = (gq[gq.size()-1] + 1) % NF;
        @(posedge clock);
        #1;
        check("cdb_valid", 64'(cdb_valid), 64'(exp_v));
        check("cdb_tag", 64'(cdb_tag), 64'(exp_tag));
        check("cdb_value", 64'(cdb_value), 64'(exp_val));
        check("cdb_take_branch", 64'(cdb_take_branch), 64'(exp_br));
        @(negedge clock);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; squash = 1'b0;
        fu_valid = '0; fu_tag = '0; fu_result = '0; fu_take_branch = '0;
        model_reset();
        #2;
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
        check("rst_cdb_value", 64'(cdb_value), 64'd0);
        check("rst_fu_ready", 64'(fu_ready), 64'hF);
        @(negedge clock);
        reset = 1'b1;

        // single result from FU2
        drive(2, 7, 'h1234, 1'b0);
        cycle();
        idle_inputs();
        cycle();
        check("single_vld", 64'(cdb_valid), 64'd1);
        check("single_tag", 64'(cdb_tag[TW-1:0]), 64'd7);
        check("single_val", 64'(cdb_value[XW-1:0]), 64'h1234);

        // wrap-around from pointer 3
        drive(3, 3, 'h33, 1'b1);
        drive(0, 20, 'h20, 1'b0);
        cycle();
        idle_inputs();
        cycle();
        check("wrap_tag0", 64'(cdb_tag[TW-1:0]), 64'd3);
        check("wrap_tag1", 64'(cdb_tag[2*TW-1:TW]), 64'd20);
        check("wrap_br", 64'(cdb_take_branch), 64'd1);

        // move pointer to 0
        drive(3, 9, 'h99, 1'b0);
        cycle();
        idle_inputs();
        cycle();

        // four-way contention
        for (int i = 0; i < NF; i++) drive(i, 10 + i, 'h100 + i, 1'b0);
        cycle();
        idle_inputs();
        #1;
        check("cont_rdy23", 64'(fu_ready[3:2]), 64'd0);
        cycle();
        check("cont_a_tag0", 64'(cdb_tag[TW-1:0]), 64'd10);
        check("cont_a_tag1", 64'(cdb_tag[2*TW-1:TW]), 64'd11);
        cycle();
        check("cont_b_tag0", 64'(cdb_tag[TW-1:0]), 64'd12);
        check("cont_b_tag1", 64'(cdb_tag[2*TW-1:TW]), 64'd13);
        cycle();

        // back-to-back on FU1
        for (int t = 1; t <= 4; t++) begin
            idle_inputs();
            drive(1, t, 'h500 + t, 1'b0);
            cycle();
            if (t >= 2) check("b2b_tag", 64'(cdb_tag[TW-1:0]), 64'(t - 1));
        end
        idle_inputs();
        cycle();
        check("b2b_last_tag", 64'(cdb_tag[TW-1:0]), 64'd4);
        cycle();

        // squash with held results
        drive(0, 21, 'hA, 1'b0);
        drive(1, 22, 'hB, 1'b0);
        cycle();
        idle_inputs();
        squash = 1'b1;
        #1;
        check("squash_rdy", 64'(fu_ready), 64'd0);
        cycle();
        check("squash_cdb", 64'(cdb_valid), 64'd0);
        squash = 1'b0;
        repeat (3) cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            fu_valid = NF'($urandom);
            for (int i = 0; i < NF; i++) begin
                fu_tag[i*TW +: TW]    = TW'($urandom);
                fu_result[i*XW +: XW] = XW'($urandom);
                fu_take_branch[i]     = 1'($urandom);
            end
            squash = ($urandom_range(0, 15) == 0);
            cycle();
        end

        // asynchronous reset mid-operation
        idle_inputs();
        for (int i = 0; i < NF; i++) drive(i, 24 + i, 'hC00 + i, 1'b1);
        cycle();
        idle_inputs();
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check("arst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("arst_cdb_value", 64'(cdb_value), 64'd0);
        check("arst_fu_ready", 64'(fu_ready), 64'hF);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (5) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
